// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared constants, fetch state encoding and byte-swap helper for
//            the multi-cycle MIPS CPU.
// Revision : 1.0
// ============================================================================
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DELIVER = 2'd1,
    HALTED  = 2'd2
  } fetch_state_t;

  // Memory bus is little-endian; the core works on big-endian words.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_fetch_unit
// Brief    : Program counter owner; fetches one word at a time, hands it to
//            the decoder and applies branch redirects after the delay slot.
// Revision : 1.0
// ============================================================================
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        active
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_target;
  logic         r_pending;
  logic         r_read;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         r_instr_valid;
  logic         r_active;

  logic         w_complete;
  logic         w_handshake;
  logic [31:0]  w_next_pc;

  // r_read is only ever high in FETCH, so it doubles as the state qualifier.
  assign w_complete  = r_read & ~waitrequest;
  assign w_handshake = r_instr_valid & instr_ready;
  assign w_next_pc   = r_pending ? r_target : (r_pc + 32'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_pc          <= RESET_VECTOR;
      r_target      <= 32'd0;
      r_pending     <= 1'b0;
      r_read        <= 1'b0;
      r_instr       <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_active      <= 1'b1;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_complete) begin
            r_read        <= 1'b0;
            r_instr       <= bswap32(readdata);
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_state       <= DELIVER;
          end else begin
            r_read <= 1'b1;
          end
        end

        DELIVER: begin
          if (w_handshake) begin
            r_instr_valid <= 1'b0;
            r_pc          <= w_next_pc;
            if (r_pending) begin
              // Delay slot accepted: the stored target takes effect now and
              // any branch sitting in the slot is dropped.
              r_pending <= 1'b0;
              if (r_target == HALT_ADDR) begin
                r_state  <= HALTED;
                r_active <= 1'b0;
              end else begin
                r_state <= FETCH;
                r_read  <= 1'b1;
              end
            end else begin
              if (redirect_valid) begin
                r_pending <= 1'b1;
                r_target  <= redirect_target;
              end
              r_state <= FETCH;
              r_read  <= 1'b1;
            end
          end
        end

        HALTED: begin
          r_read        <= 1'b0;
          r_instr_valid <= 1'b0;
          r_active      <= 1'b0;
        end

        default: begin
          r_state <= FETCH;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  assign address     = r_pc;
  assign read        = r_read;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign active      = r_active;

endmodule
`default_nettype wire

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch unit for the multi-cycle MIPS CPU. It owns the program counter and reads one instruction word at a time over the Avalon-style instruction memory master port. It presents each word, converted to MIPS big-endian order, to the instruction decoder and control unit through a valid/ready handshake. Branch and jump redirects, including the architectural branch delay slot, are applied here, and a jump to address 0 halts the CPU.

## Interface
- `RESET_VECTOR`, default 32'hBFC0_0000: first fetch address after reset.
- `HALT_ADDR`, default 32'h0000_0000: a redirect to this address ends execution.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `address`  out  32  instruction memory word address; always 4-byte aligned.
- `read`  out  1  read request.
- `waitrequest`  in  1  memory stall; the read completes in a cycle where `read & !waitrequest`.
- `readdata`  in  32  little-endian word; valid in the completing cycle.
- `instr`  out  32  fetched instruction in byte-swapped, MIPS big-endian order.
- `instr_pc`  out  32  address of `instr`.
- `instr_valid`  out  1  `instr` and `instr_pc` are valid.
- `instr_ready`  in  1  decoder accepts; the handshake is `instr_valid & instr_ready`.
- `redirect_valid`  in  1  the accepted instruction is a taken branch or jump.
- `redirect_target`  in  32  destination of that branch or jump; word aligned.
- `active`  out  1  high while the CPU runs; low once halted.

## Operation
- States: `FETCH`, `DELIVER`, `HALTED`.
- `FETCH`:
  - `read`=1 and `address`=PC.
  - `address` is held stable while `waitrequest`=1.
  - On completion, `instr` is loaded with `{readdata[7:0],readdata[15:8],readdata[23:16],readdata[31:24]}` and `instr_pc` with PC, then the unit goes to `DELIVER`.
- `DELIVER`:
  - `read`=0 and `instr_valid`=1.
  - `instr` and `instr_pc` are held stable until the handshake.
  - On handshake: if a redirect is pending and this instruction is its delay slot, PC is loaded with the pending target and the pending flag is cleared. Otherwise PC is loaded with PC+4 (mod 2^32; wraps from FFFF_FFFC to 0).
  - After the handshake the unit goes to `FETCH`, or to `HALTED` if the new PC equals `HALT_ADDR` and it was reached via a redirect.
- Redirects:
  - `redirect_valid` and `redirect_target` are sampled only in a handshake cycle.
  - The target is stored and the pending flag is set.
  - The next accepted instruction is the delay slot, fetched from PC+4. The target takes effect after the delay slot is accepted.
- Boundary rules:
  - `redirect_valid` outside a handshake cycle is ignored.
  - A redirect arriving on the delay-slot handshake (a branch in the delay slot) is ignored; the first target wins.
  - Sequential fall-through to address 0 (PC wrap) does not halt; only a redirect to `HALT_ADDR` halts.
- `HALTED`:
  - `read`=0, `instr_valid`=0, `active`=0.
  - Terminal until reset.
- Only one read is ever outstanding; there is no prefetch.

## Timing
- Reset values:
  - `address`=`RESET_VECTOR`, `read`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `active`=1.
  - Pending flag cleared; state=`FETCH`.
- First cycle after `rst_n` rises: `read`=1 with `address`=`RESET_VECTOR`.
- Latency: `instr_valid` rises in the cycle after read completion. With zero wait states and `instr_ready` tied high, throughput is one instruction per 2 cycles.
- Each waitrequest cycle adds exactly one cycle.
- Each cycle `instr_ready`=0 in `DELIVER` adds exactly one cycle.
- Reset asserted mid-read: `read` drops immediately (asynchronous). Any in-flight `readdata` is discarded and the pending redirect is lost.
- `active` falls in the cycle after the delay slot's handshake.

## Structure
- Shared package `mips_pkg` holds:
  - `RESET_VECTOR_DEFAULT` and `HALT_ADDR_DEFAULT` constants;
  - the `fetch_state_t` enum (`FETCH`/`DELIVER`/`HALTED`);
  - a `bswap32` function, shared with the load/store unit.
- No sub-module; a single sequential FSM plus PC and pending-target registers.

## Test plan
- Reset and straight line: zero wait states, `instr_ready`=1, memory returns 32'h2100_0824 at BFC0_0000. Required:
  - `instr`=32'h2408_0021 and `instr_pc`=BFC0_0000;
  - next fetch from BFC0_0004;
  - 2 cycles per instruction.
- Wait states: `waitrequest` high for 3 cycles on BFC0_0004. Required:
  - `address` and `read` stable throughout;
  - `instr_valid` 4 cycles after `read` rose.
- Backpressure: `instr_ready`=0 for 5 cycles. Required:
  - `instr` and `instr_pc` unchanged;
  - no new `read` until the handshake.
- Delay slot: `redirect_valid`=1 with target BFC0_0100 on the handshake of BFC0_0008. Required:
  - the next instruction has `instr_pc`=BFC0_000C;
  - the one after has `instr_pc`=BFC0_0100.
- Halt: redirect to 0 at BFC0_0010. Required:
  - BFC0_0014 is delivered;
  - then `active`=0 and no further `read`.
- Stray and mid-operation events:
  - `redirect_valid` pulsed while `instr_ready`=0: no effect.
  - `rst_n` pulsed low mid-read: `read`=0 asynchronously, then a restart at BFC0_0000 with `active`=1.
